// File: rtl/image_frame_buffer.sv
// Double-buffered (ping-pong) input image store. A streamed frame loads into one bank
// while the first layer reads the previous frame from the other bank through a registered port.
module image_frame_buffer #(
  parameter int PIXEL_W    = 8,
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FRAC_BITS  = 0,
  parameter int BINARIZE   = 0,
  parameter int THRESH     = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_pixel,
  input  logic               in_last,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               frame_valid,
  input  logic               frame_release,
  output logic               frame_err,
  output logic [1:0]         occupancy
);

  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [PIXEL_W-1:0] THRESH_PIX = PIXEL_W'(THRESH);

  logic [PIXEL_W-1:0] mem [2][NUM_PIXELS];

  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_cnt;
  logic [1:0]       bank_full;
  logic [1:0]       bank_full_nxt;
  logic             accept;
  logic             commit;
  logic             early_end;
  logic             release_ok;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_idx;

  function automatic logic [DATA_W-1:0] conv(input logic [PIXEL_W-1:0] pix);
    logic [DATA_W-1:0] ext;
    ext = DATA_W'(pix);
    if (BINARIZE != 0) conv = DATA_W'(pix >= THRESH_PIX);
    else               conv = ext << FRAC_BITS;
  endfunction

  assign in_ready    = !reset && !bank_full[wr_bank];
  assign frame_valid = bank_full[rd_bank];
  assign accept      = in_valid && in_ready;
  assign commit      = accept && (wr_cnt == LAST_IDX);
  assign early_end   = accept && in_last && (wr_cnt != LAST_IDX);
  assign release_ok  = frame_release && frame_valid;
  assign rd_in_range = (rd_addr <= LAST_ADDR);
  assign rd_idx      = rd_addr[IDX_W-1:0];

  // The write bank is never full and the read bank always is, so release and
  // commit in the same cycle touch different flags and both take effect.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    bank_full_nxt = bank_full;
    if (release_ok) bank_full_nxt[rd_bank] = 1'b0;
    if (commit)     bank_full_nxt[wr_bank] = 1'b1;
  end

  // NOTE: the pixel store has no reset; stale contents are never visible because reads are gated by frame_valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][wr_cnt] <= in_pixel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      bank_full <= 2'b00;
      occupancy <= 2'd0;
      frame_err <= 1'b0;
      rd_data   <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      occupancy <= {1'b0, bank_full_nxt[0]} + {1'b0, bank_full_nxt[1]};

      if (release_ok) rd_bank <= !rd_bank;

      if (commit) begin
        wr_cnt  <= '0;
        wr_bank <= !wr_bank;
        if (!in_last) frame_err <= 1'b1;
      end else if (early_end) begin
        // Short frame is dropped: the bank stays empty and is reused from pixel 0.
        wr_cnt    <= '0;
        frame_err <= 1'b1;
      end else if (accept) begin
        wr_cnt <= wr_cnt + IDX_W'(1);
      end

      if (frame_valid && rd_in_range) rd_data <= conv(mem[rd_bank][rd_idx]);
      else                            rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_image_frame_buffer.sv
// Bench for image_frame_buffer: three 16-pixel instances (plain, FRAC_BITS=8, binarized)
// share one stimulus stream and are checked against a frame-queue model plus literal values.
module tb_image_frame_buffer;

  typedef logic [7:0] frame_t [16];

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       in_last;
  logic [9:0] rd_addr;
  logic       frame_release;

  logic        in_ready_w    [3];
  logic [31:0] rd_data_w     [3];
  logic        frame_valid_w [3];
  logic        frame_err_w   [3];
  logic [1:0]  occupancy_w   [3];

  int checks = 0;
  int errors = 0;

  // Model: completed frames waiting for the consumer, oldest first.
  frame_t      m_full [$];
  frame_t      m_part;
  int          m_cnt  = 0;
  bit          m_err  = 0;
  bit          m_live = 0;
  logic [31:0] m_rd [3];

  image_frame_buffer #(.PIXEL_W(8), .NUM_PIXELS(16), .ADDR_W(10), .DATA_W(32),
                       .FRAC_BITS(0), .BINARIZE(0), .THRESH(128)) dut_plain (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_pixel(in_pixel), .in_last(in_last), .rd_addr(rd_addr), .rd_data(rd_data_w[0]),
    .frame_valid(frame_valid_w[0]), .frame_release(frame_release),
    .frame_err(frame_err_w[0]), .occupancy(occupancy_w[0]));

  image_frame_buffer #(.PIXEL_W(8), .NUM_PIXELS(16), .ADDR_W(10), .DATA_W(32),
                       .FRAC_BITS(8), .BINARIZE(0), .THRESH(128)) dut_frac (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_pixel(in_pixel), .in_last(in_last), .rd_addr(rd_addr), .rd_data(rd_data_w[1]),
    .frame_valid(frame_valid_w[1]), .frame_release(frame_release),
    .frame_err(frame_err_w[1]), .occupancy(occupancy_w[1]));

  image_frame_buffer #(.PIXEL_W(8), .NUM_PIXELS(16), .ADDR_W(10), .DATA_W(32),
                       .FRAC_BITS(0), .BINARIZE(1), .THRESH(128)) dut_bin (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_pixel(in_pixel), .in_last(in_last), .rd_addr(rd_addr), .rd_data(rd_data_w[2]),
    .frame_valid(frame_valid_w[2]), .frame_release(frame_release),
    .frame_err(frame_err_w[2]), .occupancy(occupancy_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present before the edge.
  task automatic model_step();
    int         pre;
    logic [7:0] p;
    bit         commit;
    pre    = m_full.size();
    commit = 0;
    if (reset) begin
      m_full.delete();
      m_cnt  = 0;
      m_err  = 0;
      m_live = 1;
      foreach (m_rd[k]) m_rd[k] = 32'd0;
      return;
    end
    if (!m_live) return;
    if (pre > 0 && rd_addr < 16) begin
      p = m_full[0][rd_addr[3:0]];
      m_rd[0] = 32'(p);
      m_rd[1] = 32'(p) * 256;
      m_rd[2] = (p >= 128) ? 32'd1 : 32'd0;
    end else begin
      foreach (m_rd[k]) m_rd[k] = 32'd0;
    end
    if (in_valid && pre < 2) begin
      m_part[m_cnt] = in_pixel;
      if (m_cnt == 15) begin
        commit = 1;
        if (!in_last) m_err = 1;
        m_cnt = 0;
      end else if (in_last) begin
        m_err = 1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (frame_release && pre > 0) void'(m_full.pop_front());
    if (commit) m_full.push_back(m_part);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every negedge after the first reset edge, all outputs of all instances must match the model.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("cmp_in_ready%0d", k), 32'(in_ready_w[k]),
              32'(!reset && m_full.size() < 2));
        check($sformatf("cmp_frame_valid%0d", k), 32'(frame_valid_w[k]), 32'(m_full.size() > 0));
        check($sformatf("cmp_occupancy%0d", k), 32'(occupancy_w[k]), 32'(m_full.size()));
        check($sformatf("cmp_frame_err%0d", k), 32'(frame_err_w[k]), 32'(m_err));
        check($sformatf("cmp_rd_data%0d", k), rd_data_w[k], m_rd[k]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic frame_t mk(input int base, input int step);
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = 8'(base + step * i);
    return f;
  endfunction

  // One beat held until accepted; a release pulse may ride on the accepting cycle.
  task automatic beat(input logic [7:0] pix, input bit last, input bit rel);
    int n = 0;
    in_valid = 1'b1;
    in_pixel = pix;
    in_last  = last;
    while (!in_ready_w[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("beat_accept_ready", 32'(in_ready_w[0]), 32'd1);
    if (rel) frame_release = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (rel) frame_release = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input bit with_last, input bit rel_on_last);
    for (int i = 0; i < 16; i++) beat(f[i], with_last && i == 15, rel_on_last && i == 15);
  endtask

  task automatic rd(input logic [9:0] a);
    rd_addr = a;
    @(posedge clk); #1;
  endtask

  task automatic release_pulse();
    frame_release = 1'b1;
    @(posedge clk); #1;
    frame_release = 1'b0;
  endtask

  initial begin
    frame_t f2;
    reset = 1'b1; in_valid = 1'b0; in_pixel = 8'd0; in_last = 1'b0;
    rd_addr = 10'd0; frame_release = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready_w[0]), 32'd0);
    check("reset_occupancy", 32'(occupancy_w[0]), 32'd0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(in_ready_w[0]), 32'd1);

    // Frame of 0..15: visible the cycle after its last beat.
    send_frame(mk(0, 1), 1, 0);
    check("f1_frame_valid", 32'(frame_valid_w[0]), 32'd1);
    check("f1_occupancy", 32'(occupancy_w[0]), 32'd1);
    rd(10'd5);
    check("f1_addr5_plain", rd_data_w[0], 32'd5);
    check("f1_addr5_frac", rd_data_w[1], 32'h0000_0500);
    check("f1_addr5_bin", rd_data_w[2], 32'd0);
    rd(10'd20);
    check("f1_addr20_plain", rd_data_w[0], 32'd0);
    release_pulse();
    check("f1_released_valid", 32'(frame_valid_w[0]), 32'd0);
    rd(10'd5);
    check("gated_read_plain", rd_data_w[0], 32'd0);

    // Threshold and fixed-point boundary pixels.
    f2 = mk(0, 16);
    f2[0] = 8'd127; f2[1] = 8'd128; f2[3] = 8'd255;
    send_frame(f2, 1, 0);
    rd(10'd0);
    check("f2_127_bin", rd_data_w[2], 32'd0);
    check("f2_127_plain", rd_data_w[0], 32'd127);
    rd(10'd1);
    check("f2_128_bin", rd_data_w[2], 32'd1);
    rd(10'd3);
    check("f2_255_frac", rd_data_w[1], 32'h0000_FF00);
    rd(10'd20);
    check("f2_addr20_frac", rd_data_w[1], 32'd0);

    // Both banks full, third frame stalls until a release frees a bank.
    send_frame(mk(100, 1), 1, 0);
    check("both_full_occ", 32'(occupancy_w[0]), 32'd2);
    check("both_full_ready", 32'(in_ready_w[0]), 32'd0);
    fork
      send_frame(mk(200, 1), 1, 0);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("stall_in_ready", 32'(in_ready_w[0]), 32'd0);
        check("stall_occ", 32'(occupancy_w[0]), 32'd2);
        release_pulse();
        check("freed_in_ready", 32'(in_ready_w[0]), 32'd1);
      end
    join
    check("refill_occ", 32'(occupancy_w[0]), 32'd2);
    rd(10'd2);
    check("second_frame_addr2", rd_data_w[0], 32'd102);
    release_pulse();
    rd(10'd15);
    check("third_frame_addr15", rd_data_w[0], 32'd215);

    // Last beat of a new frame coincides with releasing the current one.
    send_frame(mk(50, 1), 1, 1);
    check("swap_occ", 32'(occupancy_w[0]), 32'd1);
    rd(10'd0);
    check("swap_addr0", rd_data_w[0], 32'd50);
    release_pulse();
    check("empty_occ", 32'(occupancy_w[0]), 32'd0);

    // Early in_last on beat 6 drops the frame and sets the sticky error.
    for (int i = 0; i < 7; i++) beat(8'(i), i == 6, 0);
    check("early_err", 32'(frame_err_w[0]), 32'd1);
    check("early_valid", 32'(frame_valid_w[0]), 32'd0);
    send_frame(mk(0, 3), 1, 0);
    check("after_early_valid", 32'(frame_valid_w[0]), 32'd1);
    rd(10'd4);
    check("after_early_addr4", rd_data_w[0], 32'd12);
    release_pulse();

    // Reset arriving on beat 9 of a frame.
    for (int i = 0; i < 9; i++) beat(8'(i + 1), 0, 0);
    in_valid = 1'b1; in_pixel = 8'd99; reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_in_ready", 32'(in_ready_w[0]), 32'd0);
    check("midreset_err", 32'(frame_err_w[0]), 32'd0);
    check("midreset_valid", 32'(frame_valid_w[0]), 32'd0);
    check("midreset_rd_frac", rd_data_w[1], 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    send_frame(mk(255, -8), 1, 0);
    rd(10'd3);
    check("post_reset_plain", rd_data_w[0], 32'd231);
    check("post_reset_frac", rd_data_w[1], 32'h0000_E700);
    check("post_reset_bin", rd_data_w[2], 32'd1);

    // Full-length frame missing in_last: committed but flagged.
    send_frame(mk(0, 1), 0, 0);
    check("nolast_err", 32'(frame_err_w[0]), 32'd1);
    check("nolast_occ", 32'(occupancy_w[0]), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
